struct_record_queue: RTL
========================

// Module: struct_record_queue
// PURPOSE
//   Parametrised packed-record queue. Each entry is a record {flag, data, tag}
//   stored as one packed vector. A small FSM lets the host push records,
//   read any single field of the head record (peek or pop), and update one
//   head field in place. It is the runtime store for compiled record/struct
//   accesses in generated V# designs.
// PARAMETERS
//   DATA_W  32  width of data field
//   TAG_W   8   width of tag field
//   DEPTH   4   entry count; power of 2, >=2
//   Derived: REC_W = 1+DATA_W+TAG_W (default 41); layout [REC_W-1]=flag,
//   [REC_W-2:TAG_W]=data, [TAG_W-1:0]=tag; CNT_W = $clog2(DEPTH)+1
// PORTS
//   clk        in   1        clock, rising edge
//   reset      in   1        asynchronous, active-low reset
//   wr_valid   in   1        push request
//   wr_ready   out  1        queue not full; push accepted when valid&ready
//   wr_flag    in   1        flag field of pushed record
//   wr_data    in   DATA_W   data field of pushed record
//   wr_tag     in   TAG_W    tag field of pushed record
//   rd_req     in   1        field read request (accepted only in IDLE)
//   rd_pop     in   1        with rd_req: 1=remove head after read, 0=peek
//   field_sel  in   2        0=data, 1=tag, 2=flag, 3=reserved (reads as 0)
//   upd_valid  in   1        in-place update of selected head field
//   upd_value  in   DATA_W   update value; truncated to field width
//   out1       out  DATA_W   read result, field zero-extended to DATA_W
//   out_valid  out  1        out1 holds a fresh result this cycle
//   rd_err     out  1        read/update attempted on empty queue
//   count      out  CNT_W    occupied entries
// BEHAVIOUR
//   Reset (reset=0, async): wr_ptr, rd_ptr and count = 0. out1, out_valid and
//     rd_err = 0. FSM enters INIT. Storage contents are don't-care.
//   FSM: INIT -> IDLE. INIT lasts 1 cycle; wr_ready=0 and all requests are
//     ignored. IDLE -> EMIT on an accepted rd_req or upd_valid. EMIT -> IDLE
//     unconditionally. In EMIT, rd_req and upd_valid are ignored (no queueing).
//   Push: accepted in IDLE or EMIT when count<DEPTH. The record is written at
//     wr_ptr; wr_ptr wraps modulo DEPTH. A push while full is dropped silently.
//   Read (IDLE, rd_req=1, upd_valid=0, count>0): the selected head field is
//     registered. out1 and out_valid=1 appear in the EMIT cycle, so latency is
//     1 cycle. If rd_pop=1, rd_ptr advances and count decrements in that same
//     EMIT edge.
//   Update (IDLE, upd_valid=1, count>0): upd_value[W-1:0] is written into the
//     selected field of the head record. The other fields are preserved.
//     field_sel=3 writes nothing. In EMIT: out_valid=1 and out1 = new field
//     value. Update has priority over a same-cycle rd_req; that rd_req is
//     dropped.
//   Empty: an accepted rd_req or upd_valid with count=0 still enters EMIT,
//     with out_valid=1, out1=0, rd_err=1, and no pointer change.
//   Simultaneous push and pop: count stays unchanged, both pointers advance.
//     If the queue is full, the push is still refused (wr_ready is registered
//     from count, not from the pop). If count=0, the pushed record is not
//     visible to a same-cycle read.
//   out_valid and rd_err are 1-cycle pulses. out1 holds its last value until
//     the next EMIT.
//   Reset asserted mid-operation aborts any EMIT immediately. All outputs
//     return to their reset values.
// TESTING
//   T1 push {0,100,10}; read data, peek -> after 1 cycle out1=100, out_valid=1,
//      count=1
//   T2 same head: read tag, then flag -> out1=10, then out1=0; rd_err=0
//   T3 upd field_sel=0 with value 200, then read data with pop -> out1=200
//      both times, count=0
//   T4 push DEPTH+1 records with data 1..5 -> wr_ready=0 after 4; pops return
//      1,2,3,4; 5 dropped; pointers wrap
//   T5 read on empty -> out_valid=1, out1=0, rd_err=1, count=0
//   T6 reset low during EMIT while count=2 -> out_valid=0 at once, count=0;
//      INIT cycle refuses push

Source files
------------

// File: rtl/struct_record_queue.sv
// -----------------------------------------------------------------------------
// struct_record_queue
//   Circular queue of packed records {flag, data, tag}. The host pushes whole
//   records. Through a small INIT/IDLE/EMIT FSM it can also read one field of
//   the head record (peek or pop), or rewrite one head field in place.
//
//   The record layout matches a packed struct whose first member is the MSB:
//     [REC_W-1]      flag
//     [REC_W-2:TAG_W] data
//     [TAG_W-1:0]    tag
//
//   DEPTH must be a power of two (>= 2) so that the pointers wrap naturally.
//   TAG_W must not exceed DATA_W, because updates take their value from a
//   DATA_W-wide port.
// -----------------------------------------------------------------------------
module struct_record_queue #(
  parameter  int DATA_W = 32,
  parameter  int TAG_W  = 8,
  parameter  int DEPTH  = 4,
  localparam int REC_W  = 1 + DATA_W + TAG_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low
  // push side
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_flag,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAG_W-1:0]  wr_tag,
  // head access side
  input  logic              rd_req,
  input  logic              rd_pop,
  input  logic [1:0]        field_sel,
  input  logic              upd_valid,
  input  logic [DATA_W-1:0] upd_value,
  // results
  output logic [DATA_W-1:0] out1,
  output logic              out_valid,
  output logic              rd_err,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  // Field selector encoding; 3 is reserved and reads/writes nothing.
  localparam logic [1:0] SEL_DATA = 2'd0;
  localparam logic [1:0] SEL_TAG  = 2'd1;
  localparam logic [1:0] SEL_FLAG = 2'd2;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,   // one settling cycle after reset, refuses everything
    S_IDLE = 2'd1,   // accepts pushes and head accesses
    S_EMIT = 2'd2    // result is on out1; head accesses are ignored
  } state_e;

  typedef struct packed {
    logic              flag;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
  } rec_t;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e           state;
  state_e           state_nx;

  rec_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  rec_t             head;
  rec_t             wr_rec;
  logic             is_empty;
  logic             push_fire;
  logic             req_fire;
  logic             upd_fire;
  logic             rd_fire;
  logic             pop_fire;

  logic [DATA_W-1:0] head_field;
  logic [DATA_W-1:0] upd_field;
  logic [DATA_W-1:0] emit_value;

  assign head   = mem[rd_ptr];
  assign wr_rec = '{flag: wr_flag, data: wr_data, tag: wr_tag};

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // State register; reset drops straight into INIT, aborting any EMIT.
  // NOTE: sequential state is always written with <= so every register samples
  // the pre-edge values of its neighbours; a blocking = here would make the
  // result depend on statement order and mis-simulate against the netlist.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // INIT always moves on; IDLE leaves only for an accepted head access; EMIT
  // lasts exactly one cycle so no access can be queued behind another.
  // NOTE: state_nx gets a default before the case so every path assigns it;
  // a missing assignment in a combinational block infers a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT:  state_nx = S_IDLE;
      S_IDLE:  if (req_fire) state_nx = S_EMIT;
      S_EMIT:  state_nx = S_IDLE;
      default: state_nx = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // wr_ready looks at the registered count only, so a pop in the same cycle
  // never frees a slot for a push while the queue is full.
  always_comb begin
    wr_ready  = (state != S_INIT) && (count < DEPTH_CNT);
    out_valid = (state == S_EMIT);
  end

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // An update wins over a same-cycle read. An access to an empty queue still
  // enters EMIT, but it touches neither the storage nor the pointers.
  always_comb begin
    is_empty  = (count == '0);
    push_fire = wr_valid && wr_ready;
    req_fire  = (state == S_IDLE) && (rd_req || upd_valid);
    upd_fire  = req_fire && upd_valid && !is_empty;
    rd_fire   = req_fire && !upd_valid && !is_empty;
    pop_fire  = rd_fire && rd_pop;
  end

  // ---------------------------------------------------------------------------
  // Field extraction / update value shaping
  // ---------------------------------------------------------------------------
  // Selected head field, zero-extended to the out1 width.
  always_comb begin
    head_field = '0;
    unique case (field_sel)
      SEL_DATA: head_field = head.data;
      SEL_TAG:  head_field = DATA_W'(head.tag);
      SEL_FLAG: head_field = DATA_W'(head.flag);
      default:  head_field = '0;
    endcase
  end

  // Value the updated field will hold after truncation to the field width;
  // this is what out1 reports after an update.
  always_comb begin
    upd_field = '0;
    unique case (field_sel)
      SEL_DATA: upd_field = upd_value;
      SEL_TAG:  upd_field = DATA_W'(upd_value[TAG_W-1:0]);
      SEL_FLAG: upd_field = DATA_W'(upd_value[0]);
      default:  upd_field = '0;
    endcase
  end

  // Result captured on entry to EMIT: zero for an empty queue, the new field
  // for an update, otherwise the current head field.
  always_comb begin
    if (is_empty)       emit_value = '0;
    else if (upd_valid) emit_value = upd_field;
    else                emit_value = head_field;
  end

  // ---------------------------------------------------------------------------
  // Pointers and occupancy
  // ---------------------------------------------------------------------------
  // Pointers wrap through the power-of-two depth. A push and a pop in the
  // same cycle move both pointers and leave count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fire)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_fire, pop_fire})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  // out1 holds its value between EMITs; rd_err is a one-cycle pulse that
  // lines up with out_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out1   <= '0;
      rd_err <= 1'b0;
    end else begin
      rd_err <= req_fire && is_empty;
      if (req_fire) out1 <= emit_value;
    end
  end

  // ---------------------------------------------------------------------------
  // Record storage
  // ---------------------------------------------------------------------------
  // Pushes write a whole record at wr_ptr, and updates rewrite one field at
  // rd_ptr. The two cannot collide: an update needs count>0 and a push needs
  // count<DEPTH, so the pointers differ whenever both fire.
  // NOTE: the storage array has no reset. Its contents are don't-care until
  // written, and leaving the reset off lets it map onto plain RAM or flops
  // without reset routing.
  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr] <= wr_rec;
    if (upd_fire) begin
      unique case (field_sel)
        SEL_DATA: mem[rd_ptr].data <= upd_value;
        SEL_TAG:  mem[rd_ptr].tag  <= upd_value[TAG_W-1:0];
        SEL_FLAG: mem[rd_ptr].flag <= upd_value[0];
        default:  ;
      endcase
    end
  end

endmodule
